// File: rtl/noc_pkg.sv
// Shared packet layout and widths for the node network interface.
package noc_pkg;

   localparam int PKT_W   = 64;
   localparam int DATA_W  = 32;
   localparam int COORD_W = 16;

   localparam int Y_HI = 63;
   localparam int Y_LO = 48;
   localparam int X_HI = 47;
   localparam int X_LO = 32;
   localparam int D_HI = 31;
   localparam int D_LO = 0;

   typedef struct packed {
      logic [COORD_W-1:0]       y;
      logic [COORD_W-1:0]       x;
      logic signed [DATA_W-1:0] data;
   } noc_pkt_t;

endpackage

// File: rtl/noc_sync_fifo.sv
// First-word-fall-through synchronous FIFO with exact occupancy count.
// Head reads as zero while empty so downstream outputs are clean after reset.
module noc_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/noc_net_iface.sv
// CPU-side network interface of a mesh node: TX packet FIFO, RX payload FIFO, arrival/misroute pulses.
// Optional macro NI_LOOPBACK_EN routes self-addressed CPU requests straight into the RX FIFO.
module noc_net_iface
   import noc_pkg::*;
#(
   parameter int X_ID     = 1,
   parameter int Y_ID     = 1,
   parameter int TX_DEPTH = 4,
   parameter int RX_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cpu_tx_valid,
   output logic                          cpu_tx_ready,
   input  logic signed [DATA_W-1:0]      cpu_tx_data,
   input  logic [COORD_W-1:0]            cpu_tx_x,
   input  logic [COORD_W-1:0]            cpu_tx_y,
   output logic                          net_tx_valid,
   input  logic                          net_tx_ready,
   output logic [PKT_W-1:0]              net_tx_pkt,
   input  logic                          net_rx_valid,
   output logic                          net_rx_ready,
   input  logic [PKT_W-1:0]              net_rx_pkt,
   output logic                          cpu_rx_valid,
   input  logic                          cpu_rx_ack,
   output logic signed [DATA_W-1:0]      cpu_rx_data,
   output logic                          set_fi,
   output logic                          rx_misroute,
   output logic [$clog2(TX_DEPTH):0]     tx_count,
   output logic [$clog2(RX_DEPTH):0]     rx_count
);

   localparam logic [COORD_W-1:0] LP_X = COORD_W'(X_ID);
   localparam logic [COORD_W-1:0] LP_Y = COORD_W'(Y_ID);
   localparam int RCW = $clog2(RX_DEPTH) + 1;

   noc_pkt_t          w_tx_pkt;
   noc_pkt_t          w_rx_pkt;
   logic              w_tx_full;
   logic              w_tx_empty;
   logic              w_tx_push;
   logic              w_tx_pop;
   logic              w_rx_full;
   logic              w_rx_empty;
   logic              w_rx_push;
   logic              w_rx_pop;
   logic [DATA_W-1:0] w_rx_wdata;
   logic [DATA_W-1:0] w_rx_head;
   logic              w_net_acc;
   logic              w_rx_own;
   logic              r_set_fi;
   logic              r_misroute;

   assign w_tx_pkt   = '{y: cpu_tx_y, x: cpu_tx_x, data: cpu_tx_data};
   assign w_rx_pkt   = noc_pkt_t'(net_rx_pkt);
   assign w_net_acc  = net_rx_valid & net_rx_ready;
   assign w_rx_own   = (w_rx_pkt.x == LP_X) && (w_rx_pkt.y == LP_Y);

`ifdef NI_LOOPBACK_EN
   logic w_self;
   logic w_lb_push;

   // Network traffic owns the RX write port; a loopback request waits for it.
   assign w_self       = (cpu_tx_x == LP_X) && (cpu_tx_y == LP_Y);
   assign cpu_tx_ready = w_self ? (~w_rx_full & ~w_net_acc) : ~w_tx_full;
   assign w_tx_push    = cpu_tx_valid & cpu_tx_ready & ~w_self;
   assign w_lb_push    = cpu_tx_valid & cpu_tx_ready & w_self;
   assign w_rx_push    = (w_net_acc & w_rx_own) | w_lb_push;
   assign w_rx_wdata   = w_lb_push ? cpu_tx_data : w_rx_pkt.data;
`else
   assign cpu_tx_ready = ~w_tx_full;
   assign w_tx_push    = cpu_tx_valid & cpu_tx_ready;
   assign w_rx_push    = w_net_acc & w_rx_own;
   assign w_rx_wdata   = w_rx_pkt.data;
`endif

   assign net_tx_valid = ~w_tx_empty;
   assign w_tx_pop     = net_tx_valid & net_tx_ready;
   assign net_rx_ready = ~w_rx_full;
   assign cpu_rx_valid = ~w_rx_empty;
   assign w_rx_pop     = cpu_rx_valid & cpu_rx_ack;
   assign cpu_rx_data  = w_rx_head;
   assign set_fi       = r_set_fi;
   assign rx_misroute  = r_misroute;

   noc_sync_fifo #(.WIDTH(PKT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_tx_push),
      .i_data  (w_tx_pkt),
      .i_pop   (w_tx_pop),
      .o_data  (net_tx_pkt),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty),
      .o_count (tx_count)
   );

   noc_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_rx_push),
      .i_data  (w_rx_wdata),
      .i_pop   (w_rx_pop),
      .o_data  (w_rx_head),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty),
      .o_count (rx_count)
   );

   // A push that lands while the last entry is being popped still counts as an arrival.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_set_fi   <= 1'b0;
         r_misroute <= 1'b0;
      end else begin
         r_set_fi   <= w_rx_push & ((rx_count == '0) | ((rx_count == RCW'(1)) & w_rx_pop));
         r_misroute <= w_net_acc & ~w_rx_own;
      end
   end

endmodule

// File: tb/tb_noc_net_iface.sv
// Directed bench for noc_net_iface: TX ordering/backpressure, RX arrival/misroute/full, loopback and reset.
module tb_noc_net_iface;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_tx_valid = 1'b0;
   logic        cpu_tx_ready;
   logic signed [31:0] cpu_tx_data = '0;
   logic [15:0] cpu_tx_x = '0;
   logic [15:0] cpu_tx_y = '0;
   logic        net_tx_valid;
   logic        net_tx_ready = 1'b0;
   logic [63:0] net_tx_pkt;
   logic        net_rx_valid = 1'b0;
   logic        net_rx_ready;
   logic [63:0] net_rx_pkt = '0;
   logic        cpu_rx_valid;
   logic        cpu_rx_ack = 1'b0;
   logic signed [31:0] cpu_rx_data;
   logic        set_fi;
   logic        rx_misroute;
   logic [2:0]  tx_count;
   logic [2:0]  rx_count;

   int n_checks = 0;
   int n_fail   = 0;

   noc_net_iface #(.X_ID(1), .Y_ID(1), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cpu_tx_valid (cpu_tx_valid),
      .cpu_tx_ready (cpu_tx_ready),
      .cpu_tx_data  (cpu_tx_data),
      .cpu_tx_x     (cpu_tx_x),
      .cpu_tx_y     (cpu_tx_y),
      .net_tx_valid (net_tx_valid),
      .net_tx_ready (net_tx_ready),
      .net_tx_pkt   (net_tx_pkt),
      .net_rx_valid (net_rx_valid),
      .net_rx_ready (net_rx_ready),
      .net_rx_pkt   (net_rx_pkt),
      .cpu_rx_valid (cpu_rx_valid),
      .cpu_rx_ack   (cpu_rx_ack),
      .cpu_rx_data  (cpu_rx_data),
      .set_fi       (set_fi),
      .rx_misroute  (rx_misroute),
      .tx_count     (tx_count),
      .rx_count     (rx_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [15:0] x;
      logic [15:0] y;
      logic [63:0] exp_pkt;
   } tx_vec_t;

   typedef struct {
      logic [63:0] pkt;
      logic [2:0]  exp_count;
      logic        exp_fi;
      logic        exp_mis;
      logic [31:0] exp_head;
   } rx_vec_t;

   tx_vec_t tx_tab [3];
   rx_vec_t rx_tab [5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tx_tab[0] = '{32'd5, 16'd2, 16'd1, 64'h0001_0002_0000_0005};
      tx_tab[1] = '{32'd6, 16'd2, 16'd1, 64'h0001_0002_0000_0006};
      tx_tab[2] = '{32'd7, 16'd2, 16'd1, 64'h0001_0002_0000_0007};

      rx_tab[0] = '{64'h0001_0001_FFFF_FFFD, 3'd1, 1'b1, 1'b0, 32'hFFFF_FFFD};
      rx_tab[1] = '{64'h0001_0001_0000_0008, 3'd2, 1'b0, 1'b0, 32'hFFFF_FFFD};
      rx_tab[2] = '{64'h0002_0001_0000_0009, 3'd2, 1'b0, 1'b1, 32'hFFFF_FFFD};
      rx_tab[3] = '{64'h0001_0001_0000_0014, 3'd3, 1'b0, 1'b0, 32'hFFFF_FFFD};
      rx_tab[4] = '{64'h0001_0001_0000_0015, 3'd4, 1'b0, 1'b0, 32'hFFFF_FFFD};

      // Reset state
      tick();
      tick();
      chk("rst_tx_count", 64'(tx_count), 64'd0);
      chk("rst_rx_count", 64'(rx_count), 64'd0);
      chk("rst_net_tx_valid", 64'(net_tx_valid), 64'd0);
      chk("rst_cpu_rx_valid", 64'(cpu_rx_valid), 64'd0);
      chk("rst_net_tx_pkt", net_tx_pkt, 64'd0);
      chk("rst_cpu_rx_data", 64'($unsigned(cpu_rx_data)), 64'd0);
      chk("rst_set_fi", 64'(set_fi), 64'd0);
      chk("rst_misroute", 64'(rx_misroute), 64'd0);
      rst_n = 1'b1;
      tick();

      // TX streaming with the router always ready
      net_tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cpu_tx_valid = 1'b1;
         cpu_tx_data  = tx_tab[i].d;
         cpu_tx_x     = tx_tab[i].x;
         cpu_tx_y     = tx_tab[i].y;
         #1;
         chk($sformatf("t1_ready%0d", i), 64'(cpu_tx_ready), 64'd1);
         tick();
         chk($sformatf("t1_pkt%0d", i), net_tx_pkt, tx_tab[i].exp_pkt);
         chk($sformatf("t1_valid%0d", i), 64'(net_tx_valid), 64'd1);
         chk($sformatf("t1_count%0d", i), 64'(tx_count), 64'd1);
      end
      cpu_tx_valid = 1'b0;
      tick();
      chk("t1_drained_valid", 64'(net_tx_valid), 64'd0);
      chk("t1_drained_pkt", net_tx_pkt, 64'd0);

      // TX backpressure: fills at 4, fifth request refused
      net_tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cpu_tx_valid = 1'b1;
         cpu_tx_data  = 32'(10 + i);
         cpu_tx_x     = 16'd2;
         cpu_tx_y     = 16'd1;
         #1;
         chk($sformatf("t2_ready%0d", i), 64'(cpu_tx_ready), (i < 4) ? 64'd1 : 64'd0);
         tick();
      end
      cpu_tx_valid = 1'b0;
      chk("t2_full_count", 64'(tx_count), 64'd4);
      net_tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("t2_drain%0d", i), net_tx_pkt, {16'd1, 16'd2, 32'(10 + i)});
         tick();
      end
      chk("t2_empty_count", 64'(tx_count), 64'd0);
      net_tx_ready = 1'b0;

      // RX arrivals, misroute and fill
      for (int i = 0; i < 5; i++) begin
         net_rx_valid = 1'b1;
         net_rx_pkt   = rx_tab[i].pkt;
         #1;
         chk($sformatf("rx_ready%0d", i), 64'(net_rx_ready), 64'd1);
         tick();
         net_rx_valid = 1'b0;
         chk($sformatf("rx_count%0d", i), 64'(rx_count), 64'(rx_tab[i].exp_count));
         chk($sformatf("rx_set_fi%0d", i), 64'(set_fi), 64'(rx_tab[i].exp_fi));
         chk($sformatf("rx_misroute%0d", i), 64'(rx_misroute), 64'(rx_tab[i].exp_mis));
         chk($sformatf("rx_head%0d", i), 64'($unsigned(cpu_rx_data)), 64'(rx_tab[i].exp_head));
      end
      chk("rx_valid_full", 64'(cpu_rx_valid), 64'd1);

      // Full RX: offered packet waits one cycle while the CPU pops
      net_rx_valid = 1'b1;
      net_rx_pkt   = 64'h0001_0001_0000_0016;
      #1;
      chk("t5_ready_full", 64'(net_rx_ready), 64'd0);
      cpu_rx_ack = 1'b1;
      tick();
      cpu_rx_ack = 1'b0;
      chk("t5_count_after_pop", 64'(rx_count), 64'd3);
      chk("t5_head_after_pop", 64'($unsigned(cpu_rx_data)), 64'd8);
      #1;
      chk("t5_ready_again", 64'(net_rx_ready), 64'd1);
      tick();
      net_rx_valid = 1'b0;
      chk("t5_count_refill", 64'(rx_count), 64'd4);
      chk("t5_no_fi", 64'(set_fi), 64'd0);
      cpu_rx_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("t5_pop%0d", i), 64'($unsigned(cpu_rx_data)), (i == 0) ? 64'd8 : 64'(19 + i));
         tick();
      end
      chk("t5_last_head", 64'($unsigned(cpu_rx_data)), 64'd22);
      net_rx_valid = 1'b1;
      net_rx_pkt   = 64'h0001_0001_0000_001E;
      tick();
      net_rx_valid = 1'b0;
      chk("pushpop_count", 64'(rx_count), 64'd1);
      chk("pushpop_head", 64'($unsigned(cpu_rx_data)), 64'd30);
      chk("pushpop_set_fi", 64'(set_fi), 64'd1);
      tick();
      cpu_rx_ack = 1'b0;
      chk("rx_empty_valid", 64'(cpu_rx_valid), 64'd0);
      chk("rx_empty_data", 64'($unsigned(cpu_rx_data)), 64'd0);
      chk("rx_empty_fi", 64'(set_fi), 64'd0);

      // Self-addressed request, then mid-stream reset
      net_tx_ready = 1'b0;
      cpu_tx_valid = 1'b1;
      cpu_tx_data  = 32'sd42;
      cpu_tx_x     = 16'd1;
      cpu_tx_y     = 16'd1;
      #1;
      chk("t6_ready", 64'(cpu_tx_ready), 64'd1);
      tick();
`ifdef NI_LOOPBACK_EN
      chk("t6_lb_rx_valid", 64'(cpu_rx_valid), 64'd1);
      chk("t6_lb_rx_data", 64'($unsigned(cpu_rx_data)), 64'd42);
      chk("t6_lb_set_fi", 64'(set_fi), 64'd1);
      chk("t6_lb_no_tx", 64'(net_tx_valid), 64'd0);
`else
      chk("t6_tx_valid", 64'(net_tx_valid), 64'd1);
      chk("t6_tx_pkt", net_tx_pkt, 64'h0001_0001_0000_002A);
      chk("t6_rx_count", 64'(rx_count), 64'd0);
`endif
      cpu_tx_data = 32'sd43;
      cpu_tx_x    = 16'd2;
      tick();
      cpu_tx_valid = 1'b0;
`ifdef NI_LOOPBACK_EN
      chk("t6_tx_count", 64'(tx_count), 64'd1);
`else
      chk("t6_tx_count", 64'(tx_count), 64'd2);
`endif
      rst_n = 1'b0;
      #1;
      chk("t6_arst_tx_count", 64'(tx_count), 64'd0);
      chk("t6_arst_rx_count", 64'(rx_count), 64'd0);
      chk("t6_arst_tx_pkt", net_tx_pkt, 64'd0);
      chk("t6_arst_rx_valid", 64'(cpu_rx_valid), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6_post_tx_count", 64'(tx_count), 64'd0);
      chk("t6_post_rx_count", 64'(rx_count), 64'd0);
      chk("t6_post_set_fi", 64'(set_fi), 64'd0);
      chk("t6_post_tx_valid", 64'(net_tx_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
